// File: rtl/obi_arb_pkg.sv
// Shared types and defaults for the per-bank OBI round-robin arbiter.
// The master-index width helper keeps a 1-bit minimum so degenerate sizes still elaborate.
package obi_arb_pkg;

  localparam int DEFAULT_NUM_MASTER      = 4;
  localparam int DEFAULT_MAX_OUTSTANDING = 2;

  typedef logic [$clog2(DEFAULT_NUM_MASTER)-1:0] master_idx_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_bank_rr_arbiter_id_fifo.sv
// In-order FIFO of master indices for granted, still-unanswered bank transactions.
// Shares the arbiter's asynchronous active-high reset; storage itself is not reset.
module obi_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = DEFAULT_MAX_OUTSTANDING,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_o  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({push_i, pop_i})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_o == CNT_W'(DEPTH));
  assign empty_o = (count_o == '0);

endmodule

// File: rtl/obi_bank_rr_arbiter.sv
// Round-robin arbiter sharing one data-memory bank OBI port between NUM_MASTER requesters.
// Granted master indices are queued in order so each bank response is routed to its issuer.
module obi_bank_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter int NUM_MASTER      = DEFAULT_NUM_MASTER,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_MASTER-1:0]              m_req_i,
  output logic [NUM_MASTER-1:0]              m_gnt_o,
  input  logic [NUM_MASTER*ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_MASTER-1:0]              m_we_i,
  input  logic [NUM_MASTER*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTER*DATA_WIDTH-1:0]   m_wdata_i,
  output logic [NUM_MASTER-1:0]              m_rvalid_o,
  output logic [DATA_WIDTH-1:0]              m_rdata_o,
  output logic                               s_req_o,
  input  logic                               s_gnt_i,
  output logic [ADDR_WIDTH-1:0]              s_addr_o,
  output logic                               s_we_o,
  output logic [DATA_WIDTH/8-1:0]            s_be_o,
  output logic [DATA_WIDTH-1:0]              s_wdata_o,
  input  logic                               s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]              s_rdata_i,
  output logic                               err_o
);

  localparam int IDX_W = idx_width(NUM_MASTER);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;

  idx_t             rr_ptr_q;
  idx_t             lock_idx_q;
  logic             lock_q;
  idx_t             win;
  idx_t             head;
  logic             any_req;
  logic             handshake;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  function automatic idx_t rr_pick(input logic [NUM_MASTER-1:0] req, input idx_t ptr);
    idx_t pick  = ptr;
    logic found = 1'b0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      int j = (int'(ptr) + i) % NUM_MASTER;
      if (!found && req[j]) begin
        pick  = idx_t'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // A master left waiting for gnt keeps the port until it is granted (OBI stability).
  always_comb begin
    any_req   = |m_req_i;
    win       = (lock_q && m_req_i[lock_idx_q]) ? lock_idx_q : rr_pick(m_req_i, rr_ptr_q);
    s_req_o   = any_req && !(fifo_full && !s_rvalid_i);
    handshake = s_req_o && s_gnt_i;
    pop       = s_rvalid_i && (fifo_count != '0);
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = pop ? s_rdata_i : '0;
    if (any_req) begin
      s_addr_o  = m_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
      s_we_o    = m_we_i[win];
      s_be_o    = m_be_i[win*BE_W +: BE_W];
      s_wdata_o = m_wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < NUM_MASTER; i++) begin
      m_gnt_o[i]    = handshake && (win == idx_t'(i));
      m_rvalid_o[i] = pop && (head == idx_t'(i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_o      <= 1'b0;
    end else begin
      if (handshake) rr_ptr_q <= (win == idx_t'(NUM_MASTER - 1)) ? '0 : win + 1'b1;
      lock_q     <= s_req_o && !s_gnt_i;
      lock_idx_q <= win;
      if (s_rvalid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  obi_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (win),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_obi_bank_rr_arbiter.sv
// Scoreboard bench for obi_bank_rr_arbiter: directed stimulus pushes expected grants and
// responses; independent monitors pop and compare whenever the DUT presents gnt or rvalid.
module tb_obi_bank_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NM-1:0]     m_req_i;
  logic [NM-1:0]     m_gnt_o;
  logic [NM*AW-1:0]  m_addr_i;
  logic [NM-1:0]     m_we_i;
  logic [NM*BW-1:0]  m_be_i;
  logic [NM*DW-1:0]  m_wdata_i;
  logic [NM-1:0]     m_rvalid_o;
  logic [DW-1:0]     m_rdata_o;
  logic              s_req_o;
  logic              s_gnt_i;
  logic [AW-1:0]     s_addr_o;
  logic              s_we_o;
  logic [BW-1:0]     s_be_o;
  logic [DW-1:0]     s_wdata_o;
  logic              s_rvalid_i = 1'b0;
  logic [DW-1:0]     s_rdata_i = '0;
  logic              err_o;

  logic [AW-1:0] addr_a  [NM];
  logic [DW-1:0] wdata_a [NM];

  int total = 0;
  int bad   = 0;

  int            exp_gnt   [$];
  int            exp_rsp_m [$];
  logic [DW-1:0] exp_rsp_d [$];

  logic [DW-1:0] bank_mem [logic [AW-1:0]];
  logic [DW-1:0] bank_q   [$];
  logic          rsp_stall = 1'b0;
  logic          spur      = 1'b0;

  obi_bank_rr_arbiter #(
    .NUM_MASTER      (NM),
    .MAX_OUTSTANDING (2),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m_req_i    (m_req_i),
    .m_gnt_o    (m_gnt_o),
    .m_addr_i   (m_addr_i),
    .m_we_i     (m_we_i),
    .m_be_i     (m_be_i),
    .m_wdata_i  (m_wdata_i),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_gnt_i    (s_gnt_i),
    .s_addr_o   (s_addr_o),
    .s_we_o     (s_we_o),
    .s_be_o     (s_be_o),
    .s_wdata_o  (s_wdata_o),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  assign m_be_i = '1;

  always_comb begin
    for (int m = 0; m < NM; m++) begin
      m_addr_i[m*AW +: AW]  = addr_a[m];
      m_wdata_i[m*DW +: DW] = wdata_a[m];
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NM-1:0] v);
    for (int i = 0; i < NM; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Grant and response monitors
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m_gnt_o != '0) begin
        check("gnt_onehot", 64'($onehot(m_gnt_o)), 64'd1);
        if (exp_gnt.size() == 0) check("gnt_unexpected", 64'(m_gnt_o), 64'd0);
        else check("gnt_idx", 64'(onehot_idx(m_gnt_o)), 64'(exp_gnt.pop_front()));
      end
      if (m_rvalid_o != '0) begin
        check("rvalid_onehot", 64'($onehot(m_rvalid_o)), 64'd1);
        if (exp_rsp_m.size() == 0) check("rvalid_unexpected", 64'(m_rvalid_o), 64'd0);
        else begin
          check("rsp_master", 64'(onehot_idx(m_rvalid_o)), 64'(exp_rsp_m.pop_front()));
          check("rsp_data", 64'(m_rdata_o), 64'(exp_rsp_d.pop_front()));
        end
      end
    end
  end

  // Bank model: accepts on handshake, answers one cycle later in order
  always @(negedge clk_i) begin
    if (!rst_i && s_req_o && s_gnt_i) begin
      if (s_we_o) begin
        bank_mem[s_addr_o] = s_wdata_o;
        bank_q.push_back('0);
      end else if (bank_mem.exists(s_addr_o)) begin
        bank_q.push_back(bank_mem[s_addr_o]);
      end else begin
        bank_q.push_back({16'hbeef, s_addr_o[15:0]});
      end
    end
  end

  always @(posedge clk_i) begin
    #2;
    if (rst_i) begin
      s_rvalid_i = 1'b0;
      s_rdata_i  = '0;
    end else if (!rsp_stall && bank_q.size() > 0) begin
      s_rvalid_i = 1'b1;
      s_rdata_i  = bank_q.pop_front();
    end else begin
      s_rvalid_i = spur;
      s_rdata_i  = spur ? 32'hdead_0bad : '0;
    end
  end

  always @(posedge rst_i) bank_q.delete();

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_all(input logic [NM-1:0] req, input logic [AW-1:0] base);
    m_req_i = req;
    m_we_i  = '0;
    for (int m = 0; m < NM; m++) addr_a[m] = base + AW'(4 * m);
  endtask

  task automatic push_rsp(input int m, input logic [DW-1:0] d);
    exp_rsp_m.push_back(m);
    exp_rsp_d.push_back(d);
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    m_req_i   = '0;
    m_we_i    = '0;
    s_gnt_i   = 1'b0;
    rsp_stall = 1'b0;
    spur      = 1'b0;
    for (int m = 0; m < NM; m++) begin
      addr_a[m]  = '0;
      wdata_a[m] = '0;
    end
    repeat (2) cyc();
    rst_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_gnt.size() == 0 && exp_rsp_m.size() == 0) break;
      @(negedge clk_i);
      #1;
    end
    check("drain_gnt_left", 64'(exp_gnt.size()), 64'd0);
    check("drain_rsp_left", 64'(exp_rsp_m.size()), 64'd0);
    exp_gnt.delete();
    exp_rsp_m.delete();
    exp_rsp_d.delete();
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    @(negedge clk_i);
    check("rst_s_req", 64'(s_req_o), 64'd0);
    check("rst_m_gnt", 64'(m_gnt_o), 64'd0);
    check("rst_m_rvalid", 64'(m_rvalid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_s_addr", 64'(s_addr_o), 64'd0);
    check("rst_m_rdata", 64'(m_rdata_o), 64'd0);
    cyc();

    // Single master: two writes then a read of the same word
    s_gnt_i    = 1'b1;
    m_req_i    = 4'b0100;
    m_we_i[2]  = 1'b1;
    addr_a[2]  = 32'h0;
    wdata_a[2] = 32'h11;
    repeat (3) exp_gnt.push_back(2);
    push_rsp(2, 32'h0);
    push_rsp(2, 32'h0);
    push_rsp(2, 32'h22);
    @(negedge clk_i);
    check("t1_we", 64'(s_we_o), 64'd1);
    check("t1_wdata0", 64'(s_wdata_o), 64'h11);
    cyc();
    wdata_a[2] = 32'h22;
    @(negedge clk_i);
    check("t1_wdata1", 64'(s_wdata_o), 64'h22);
    cyc();
    m_we_i[2] = 1'b0;
    cyc();
    m_req_i = '0;
    drain(10);
    check("t1_err", 64'(err_o), 64'd0);

    // All four masters requesting: strict rotation 0,1,2,3,...
    do_reset();
    s_gnt_i = 1'b1;
    set_all(4'hF, 32'h100);
    for (int k = 0; k < 8; k++) begin
      exp_gnt.push_back(k % 4);
      push_rsp(k % 4, 32'hbeef_0100 + 32'(4 * (k % 4)));
    end
    repeat (8) cyc();
    m_req_i = '0;
    drain(10);

    // Grant lock: master 1 keeps the port through a 3-cycle gnt stall even when master 0 joins
    do_reset();
    s_gnt_i   = 1'b0;
    addr_a[0] = 32'h200;
    addr_a[1] = 32'h204;
    addr_a[3] = 32'h20c;
    m_req_i   = 4'b1010;
    @(negedge clk_i);
    check("t3_addr_c0", 64'(s_addr_o), 64'h204);
    check("t3_req_c0", 64'(s_req_o), 64'd1);
    check("t3_nognt_c0", 64'(m_gnt_o), 64'd0);
    cyc();
    m_req_i = 4'b1011;
    @(negedge clk_i);
    check("t3_addr_c1", 64'(s_addr_o), 64'h204);
    cyc();
    @(negedge clk_i);
    check("t3_addr_c2", 64'(s_addr_o), 64'h204);
    cyc();
    s_gnt_i = 1'b1;
    exp_gnt.push_back(1);
    exp_gnt.push_back(3);
    exp_gnt.push_back(0);
    push_rsp(1, 32'hbeef_0204);
    push_rsp(3, 32'hbeef_020c);
    push_rsp(0, 32'hbeef_0200);
    @(negedge clk_i);
    check("t3_addr_gnt", 64'(s_addr_o), 64'h204);
    cyc();
    m_req_i = 4'b1001;
    @(negedge clk_i);
    check("t3_addr_next", 64'(s_addr_o), 64'h20c);
    cyc();
    m_req_i = 4'b0001;
    cyc();
    m_req_i = '0;
    drain(10);

    // Full ID FIFO blocks requests; a returning response lets a push and pop share a cycle
    do_reset();
    s_gnt_i   = 1'b1;
    rsp_stall = 1'b1;
    set_all(4'hF, 32'h300);
    for (int m = 0; m < 3; m++) begin
      exp_gnt.push_back(m);
      push_rsp(m, 32'hbeef_0300 + 32'(4 * m));
    end
    cyc();
    cyc();
    @(negedge clk_i);
    check("t4_block_c2", 64'(s_req_o), 64'd0);
    check("t4_nognt_c2", 64'(m_gnt_o), 64'd0);
    cyc();
    @(negedge clk_i);
    check("t4_block_c3", 64'(s_req_o), 64'd0);
    cyc();
    rsp_stall = 1'b0;
    @(negedge clk_i);
    check("t4_req_on_pop", 64'(s_req_o), 64'd1);
    cyc();
    rsp_stall = 1'b1;
    @(negedge clk_i);
    check("t4_count_held", 64'(s_req_o), 64'd0);
    cyc();
    m_req_i   = '0;
    rsp_stall = 1'b0;
    drain(10);

    // Spurious response with an empty FIFO sets the sticky error
    do_reset();
    spur = 1'b1;
    @(negedge clk_i);
    check("t5_no_rvalid", 64'(m_rvalid_o), 64'd0);
    check("t5_err_before", 64'(err_o), 64'd0);
    cyc();
    spur = 1'b0;
    @(negedge clk_i);
    check("t5_err_set", 64'(err_o), 64'd1);
    repeat (3) cyc();
    @(negedge clk_i);
    check("t5_err_sticky", 64'(err_o), 64'd1);
    cyc();

    // Asynchronous reset with two transactions outstanding
    s_gnt_i   = 1'b1;
    rsp_stall = 1'b1;
    set_all(4'hF, 32'h400);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    cyc();
    cyc();
    @(negedge clk_i);
    check("t6_full", 64'(s_req_o), 64'd0);
    check("t6_err_pre", 64'(err_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_rst_err", 64'(err_o), 64'd0);
    check("t6_rst_fifo", 64'(s_req_o), 64'd1);
    check("t6_rst_rvalid", 64'(m_rvalid_o), 64'd0);
    check("t6_gnt_drained", 64'(exp_gnt.size()), 64'd0);
    rsp_stall = 1'b0;
    exp_gnt.push_back(0);
    push_rsp(0, 32'hbeef_0400);
    cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t6_addr_after", 64'(s_addr_o), 64'h400);
    cyc();
    m_req_i = '0;
    drain(10);
    check("t6_err_after", 64'(err_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
